// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported RAM between the fetch (IF) and MEM-stage requesters.
// MEM wins ties unless IF has been passed over STARVE_LIMIT times in a row.
module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MEM_LATENCY  = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_cancel,
    output logic              if_r,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              mem_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_we_lo,
    input  logic              mem_we_hi,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_r,
    output logic [DATA_W-1:0] mem_rdata,

    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we_lo,
    output logic              ram_we_hi,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,

    output logic              busy
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CYC_INIT = CNT_W'(MEM_LATENCY - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e              state_q;
    logic                grant_mem_q;
    logic                cancel_q;
    logic [CNT_W-1:0]    cyc_cnt_q;
    logic [STV_W-1:0]    starve_cnt_q;
    logic                ram_en_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic                ram_we_lo_q;
    logic                ram_we_hi_q;
    logic [DATA_W-1:0]   ram_wdata_q;
    logic                if_r_q;
    logic                mem_r_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   mem_rdata_q;

    logic                grant_mem_d;
    logic                grant_if_d;
    logic [STV_W-1:0]    starve_cnt_d;

    // Grant decision, only acted upon while idle.
    always_comb begin
        grant_mem_d  = mem_req && !(if_req && (starve_cnt_q == STV_MAX));
        grant_if_d   = if_req && !grant_mem_d;
        starve_cnt_d = starve_cnt_q;
        if (grant_mem_d) begin
            if (!if_req) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != STV_MAX) begin
                starve_cnt_d = starve_cnt_q + STV_W'(1);
            end
        end else if (grant_if_d) begin
            starve_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_mem_q  <= 1'b0;
            cancel_q     <= 1'b0;
            cyc_cnt_q    <= '0;
            starve_cnt_q <= '0;
            ram_en_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_we_lo_q  <= 1'b0;
            ram_we_hi_q  <= 1'b0;
            ram_wdata_q  <= '0;
            if_r_q       <= 1'b0;
            mem_r_q      <= 1'b0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
        end else begin
            if_r_q  <= 1'b0;
            mem_r_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    starve_cnt_q <= starve_cnt_d;
                    if (grant_mem_d || grant_if_d) begin
                        state_q     <= ST_ACCESS;
                        grant_mem_q <= grant_mem_d;
                        cancel_q    <= grant_if_d && if_cancel;
                        cyc_cnt_q   <= CYC_INIT;
                        ram_en_q    <= 1'b1;
                        ram_addr_q  <= grant_mem_d ? mem_addr : if_addr;
                        ram_wdata_q <= grant_mem_d ? mem_wdata : '0;
                        ram_we_lo_q <= grant_mem_d && mem_we_lo;
                        ram_we_hi_q <= grant_mem_d && mem_we_hi;
                    end
                end
                ST_ACCESS: begin
                    if (!grant_mem_q && if_cancel) begin
                        cancel_q <= 1'b1;
                    end
                    if (cyc_cnt_q == '0) begin
                        state_q     <= ST_RESP;
                        ram_en_q    <= 1'b0;
                        ram_we_lo_q <= 1'b0;
                        ram_we_hi_q <= 1'b0;
                        if (grant_mem_q) begin
                            mem_rdata_q <= ram_rdata;
                            mem_r_q     <= 1'b1;
                        end else begin
                            // A cancel arriving on this very edge must still suppress the pulse.
                            if_rdata_q <= ram_rdata;
                            if_r_q     <= !(cancel_q || if_cancel);
                        end
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state_q  <= ST_IDLE;
                    cancel_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_r      = if_r_q;
    assign if_rdata  = if_rdata_q;
    assign mem_r     = mem_r_q;
    assign mem_rdata = mem_rdata_q;
    assign ram_en    = ram_en_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we_lo = ram_we_lo_q;
    assign ram_we_hi = ram_we_hi_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
